// File: rtl/lap_register_bank_pkg.sv
// Shared types and constants for the lap-time register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lap_pkg;

  localparam int DIGIT_W = 8;
  localparam int ENTRY_W = 3 * DIGIT_W;

  localparam logic MODE_RECORD = 1'b0;
  localparam logic MODE_RECALL = 1'b1;

  typedef struct packed {
    logic [DIGIT_W-1:0] min;
    logic [DIGIT_W-1:0] s;
    logic [DIGIT_W-1:0] ms;
  } entry_t;

  // Pointer width for an index range of n entries; never narrower than 1 bit.
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic entry_t pack_entry(input logic [DIGIT_W-1:0] mn,
                                        input logic [DIGIT_W-1:0] sc,
                                        input logic [DIGIT_W-1:0] msec);
    entry_t e;
    e.min = mn;
    e.s   = sc;
    e.ms  = msec;
    return e;
  endfunction

endpackage

// File: rtl/lap_register_bank_if.sv
// Bus between the stopwatch datapath (master) and the lap bank (slave).
// Latency: n/a (wiring only).
// Backpressure: none; buttons are level signals, outputs are registered levels.
interface lap_register_bank_if #(
  parameter int DIGIT_W = lap_pkg::DIGIT_W,
  parameter int SLOTS   = 8
);
  localparam int EW = 3 * DIGIT_W;
  localparam int CW = $clog2(SLOTS + 1);

  logic               MODE;
  logic               STORE;
  logic               NEXT;
  logic [DIGIT_W-1:0] min;
  logic [DIGIT_W-1:0] s;
  logic [DIGIT_W-1:0] ms;
  logic [EW-1:0]      Dout;
  logic               ZERO;
  logic [CW-1:0]      COUNT;
  logic               FULL;
  logic               EMPTY;
  logic               OVF;

  modport master (
    output MODE, STORE, NEXT, min, s, ms,
    input  Dout, ZERO, COUNT, FULL, EMPTY, OVF
  );

  modport slave (
    input  MODE, STORE, NEXT, min, s, ms,
    output Dout, ZERO, COUNT, FULL, EMPTY, OVF
  );
endinterface

// File: rtl/lap_register_bank_rise_detect.sv
// Rising-edge detector for a level button input.
// Latency: combinational pulse in the cycle the input first reads high.
// Backpressure: none; history is preset to 1 so a button held through reset fires no edge.
module rise_detect (
  input  logic CP,
  input  logic RST,
  input  logic d_i,
  output logic rise_o
);
  logic hist_q;

  // Remember last cycle's level; preset high in reset.
  always_ff @(posedge CP) begin
    if (!RST) hist_q <= 1'b1;
    else      hist_q <= d_i;
  end

  assign rise_o = d_i & ~hist_q;
endmodule

// File: rtl/lap_register_bank.sv
// Circular lap-time store: captures {min,s,ms} on STORE edges, replays oldest-first on NEXT edges in recall.
// Latency: Dout/ZERO/COUNT/FULL/EMPTY/OVF are registered, updated one edge after the triggering input edge.
// Backpressure: none; a store into a full bank sets OVF and is dropped, or overwrites the oldest entry
// when LAP_OVERWRITE_EN is defined.
module lap_register_bank
  import lap_pkg::*;
#(
  parameter int DIGIT_W = lap_pkg::DIGIT_W,
  parameter int SLOTS   = 8
) (
  input logic CP,
  input logic RST,
  lap_register_bank_if.slave bus
);
  localparam int EW = 3 * DIGIT_W;
  localparam int PW = ptr_w(SLOTS);
  localparam int CW = $clog2(SLOTS + 1);

  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PW'(SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic ptr_t ptr_dec(input ptr_t p);
    return (p == '0) ? PW'(SLOTS - 1) : p - 1'b1;
  endfunction

  logic [EW-1:0] slot_q [SLOTS];
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          oldest_q, oldest_d;
  ptr_t          rd_idx_q, rd_idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] dout_q, dout_d;
  logic          zero_q, zero_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          mode_q;

  logic          slot_we;
  ptr_t          slot_widx;
  logic [EW-1:0] slot_wdat;

  logic          st_rise;
  logic          nx_rise;

  rise_detect u_store_rise (.CP(CP), .RST(RST), .d_i(bus.STORE), .rise_o(st_rise));
  rise_detect u_next_rise  (.CP(CP), .RST(RST), .d_i(bus.NEXT),  .rise_o(nx_rise));

  // Next-state for pointers, count, flags and the displayed entry.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    oldest_d  = oldest_q;
    rd_idx_d  = rd_idx_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    dout_d    = dout_q;
    slot_we   = 1'b0;
    slot_widx = wr_ptr_q;
    slot_wdat = {bus.min, bus.s, bus.ms};

    if (bus.MODE == MODE_RECORD) begin
      if (st_rise) begin
        if (!full_q) begin
          slot_we  = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = count_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
`ifdef LAP_OVERWRITE_EN
          // When full, wr_ptr and oldest coincide; replace the oldest lap.
          slot_we   = 1'b1;
          slot_widx = oldest_q;
          oldest_d  = ptr_inc(oldest_q);
          wr_ptr_d  = ptr_inc(wr_ptr_q);
`endif
        end
      end
      // Newest entry as of this edge; a fresh store shows up one cycle later.
      dout_d = empty_q ? '0 : slot_q[ptr_dec(wr_ptr_q)];
    end else begin
      if (mode_q == MODE_RECORD) begin
        // Entering recall: restart replay from the oldest lap.
        rd_idx_d = oldest_q;
        dout_d   = empty_q ? '0 : slot_q[oldest_q];
      end else begin
        if (nx_rise && !empty_q) begin
          rd_idx_d = (rd_idx_q == ptr_dec(wr_ptr_q)) ? oldest_q : ptr_inc(rd_idx_q);
        end
        dout_d = empty_q ? '0 : slot_q[rd_idx_q];
      end
    end

    zero_d  = (dout_d == '0);
    full_d  = (count_d == CW'(SLOTS));
    empty_d = (count_d == '0);
  end

  // Control and output registers; reset clears the bank state.
  always_ff @(posedge CP) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      oldest_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      zero_q   <= 1'b1;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      mode_q   <= MODE_RECORD;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      oldest_q <= oldest_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      zero_q   <= zero_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      mode_q   <= bus.MODE;
    end
  end

  // Lap storage: cleared on reset, one write port.
  always_ff @(posedge CP) begin
    if (!RST) begin
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
    end else if (slot_we) begin
      slot_q[slot_widx] <= slot_wdat;
    end
  end

  assign bus.Dout  = dout_q;
  assign bus.ZERO  = zero_q;
  assign bus.COUNT = count_q;
  assign bus.FULL  = full_q;
  assign bus.EMPTY = empty_q;
  assign bus.OVF   = ovf_q;
endmodule
